microsequencer: RTL and testbench
=================================

# microsequencer

Registered next-state engine for the LC-3b datapath. It produces the 6-bit `stateID` consumed by the control store, which decodes it into the active-low load/enable strobes. The block walks fetch, memory wait, IR load, decode and single-cycle execute states. It also tracks retired instructions and traps on unsupported opcodes.

## Interface
Parameters:
- `CNT_W`, 16: width of the retired-instruction counter (and of the stall counter when compiled in).

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous reset, active-high.
- `ir_opcode`  in  4  IR[15:12]; valid from the cycle after state 35.
- `ben`  in  1  branch-enable from datapath; sampled only in state 0.
- `mem_ready`  in  1  memory R signal; sampled only in state 33.
- `stateID`  out  6  current microstate; registered.
- `illegal`  out  1  sticky flag for an unsupported opcode.
- `instr_retired`  out  CNT_W  count of completed instructions; wraps.
- `stall_cnt`  out  CNT_W  memory-wait cycle count; present only with `USEQ_STALL_CNT_EN`.

## Operation
- Encoded states: 18 FETCH (MAR<-PC, PC<-PC+2), 33 MEMRD, 35 LDIR, 32 DECODE, 0 BR, 22 BRTAKEN, 1 ADD, 5 AND, 9 XOR, 12 JMP, 13 SHF, 14 LEA, 63 TRAPHALT.
- Transitions:
  - 18 -> 33.
  - 33 -> 35 if `mem_ready`=1, else stays in 33.
  - 35 -> 32.
  - 32 -> `{2'b00, ir_opcode}` when the opcode is one of 0, 1, 5, 9, 12, 13, 14.
  - 32 -> 63 for any other opcode (2, 3, 4, 6, 7, 8, 10, 11, 15). `illegal` sets on entry to 63.
  - 0 -> 22 if `ben`=1, else 0 -> 18.
  - 22, 1, 5, 9, 12, 13, 14 -> 18.
  - 63 -> 63 until `rst`.
- Retire rule:
  - `instr_retired` += 1 on every transition into 18 from an execute state: 1, 5, 9, 12, 13, 14, 22, or 0 with branch not taken.
  - Wraps from 2^CNT_W-1 to 0.
  - Transitions 63->63 and 33->33 never count.
- Any `stateID` encoding outside the listed set (unreachable; e.g. SEU) -> next state 63 with `illegal` set.
- `ir_opcode` is ignored in every state except 32. `ben` is ignored in every state except 0. `mem_ready` is ignored in every state except 33.

## Timing
- Reset (synchronous, wins over all inputs, any state including mid-MEMRD):
  - `stateID`=18, `illegal`=0, `instr_retired`=0, `stall_cnt`=0.
  - The first FETCH cycle is the first cycle after `rst` is low.
- All outputs are flops. The next state is computed combinationally from the current state and inputs, then registered on the rising `clk`.
- Latency, zero-wait memory (`mem_ready`=1 on the first 33 cycle):
  - ALU/JMP/SHF/LEA instruction = 5 cycles (18, 33, 35, 32, exec).
  - BR not taken = 5 cycles; BR taken = 6 cycles.
  - Each cycle with `mem_ready`=0 in state 33 adds one cycle.
- `instr_retired` updates in the same edge that loads `stateID`=18.
- `illegal` rises in the same edge that loads `stateID`=63.

## Configuration
- `USEQ_STALL_CNT_EN` defined:
  - `stall_cnt` port exists.
  - Increments by 1 on each cycle with `stateID`=33 and `mem_ready`=0.
  - Saturates at 2^CNT_W-1; cleared only by `rst`.
- Not defined:
  - `stall_cnt` port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset with `rst`=1 for 2 cycles, then release -> `stateID`=18, `illegal`=0, `instr_retired`=0; next cycle `stateID`=33.
- ADD opcode 1, `mem_ready`=1 -> sequence 18, 33, 35, 32, 1, 18; `instr_retired`=1 after the final edge.
- BR opcode 0: `ben`=1 -> 0, 22, 18; `ben`=0 -> 0, 18. Each branch increments `instr_retired` by 1.
- `mem_ready` low for 3 cycles in state 33 -> 33 held for 4 cycles, then 35. With `USEQ_STALL_CNT_EN`, `stall_cnt`=3.
- Opcode 4 at decode -> `stateID`=63, `illegal`=1, held for 10 cycles. Assert `rst` mid-hold -> 18, `illegal`=0.
- Preload `instr_retired`=16'hFFFF via retired instructions, retire one more -> 16'h0000. Assert `rst` during a 33 wait -> `stateID`=18 next edge.

Source files
------------

// File: rtl/microsequencer.sv
// LC-3b microsequencer: registered next-state engine producing stateID for the control store.
// Optional USEQ_STALL_CNT_EN adds a saturating memory-wait cycle counter on port stall_cnt.
module microsequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ir_opcode,
  input  logic             ben,
  input  logic             mem_ready,
  output logic [5:0]       stateID,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_retired
`ifdef USEQ_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  // state       | meaning
  // ------------+---------------------------------------------
  // FETCH   18  | MAR<-PC, PC<-PC+2
  // MEMRD   33  | wait for memory ready
  // LDIR    35  | load IR from MDR
  // DECODE  32  | dispatch on ir_opcode
  // BR       0  | branch, test ben
  // BRTAKEN 22  | PC<-PC+offset
  // ADD/AND/XOR/JMP/SHF/LEA (1/5/9/12/13/14) | single-cycle execute
  // TRAPHALT 63 | unsupported opcode or corrupt state, held until rst
  typedef enum logic [5:0] {
    S_BR       = 6'd0,
    S_ADD      = 6'd1,
    S_AND      = 6'd5,
    S_XOR      = 6'd9,
    S_JMP      = 6'd12,
    S_SHF      = 6'd13,
    S_LEA      = 6'd14,
    S_FETCH    = 6'd18,
    S_BRTAKEN  = 6'd22,
    S_DECODE   = 6'd32,
    S_MEMRD    = 6'd33,
    S_LDIR     = 6'd35,
    S_TRAPHALT = 6'd63
  } state_t;

  // Plain vector so that any encoding, including a corrupted one, is representable.
  logic [5:0] state_q;
  logic [5:0] state_d;
  logic       retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_TRAPHALT;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_LDIR : S_MEMRD;
      S_LDIR:   state_d = S_DECODE;
      S_DECODE: begin
        case (ir_opcode)
          4'd0, 4'd1, 4'd5, 4'd9, 4'd12, 4'd13, 4'd14: state_d = {2'b00, ir_opcode};
          default:                                     state_d = S_TRAPHALT;
        endcase
      end
      S_BR: begin
        if (ben) begin
          state_d = S_BRTAKEN;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_BRTAKEN, S_ADD, S_AND, S_XOR, S_JMP, S_SHF, S_LEA: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAPHALT: state_d = S_TRAPHALT;
      default:    state_d = S_TRAPHALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal <= 1'b0;
    end else if (state_d == S_TRAPHALT) begin
      illegal <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_retired <= '0;
    end else if (retire) begin
      instr_retired <= instr_retired + CNT_W'(1);
    end
  end

`ifdef USEQ_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state_q == S_MEMRD) && !mem_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

  assign stateID = state_q;

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer; a 16-bit and a 4-bit counter instance share stimulus
// so counter wrap and stall saturation are reachable in a short run.
module tb_microsequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ir_opcode = 4'd0;
  logic        ben = 1'b0;
  logic        mem_ready = 1'b1;

  logic [5:0]  sid16, sid4;
  logic        ill16, ill4;
  logic [15:0] ret16;
  logic [3:0]  ret4;
`ifdef USEQ_STALL_CNT_EN
  logic [15:0] stall16;
  logic [3:0]  stall4;
`endif

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  microsequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ir_opcode(ir_opcode), .ben(ben), .mem_ready(mem_ready),
    .stateID(sid16), .illegal(ill16), .instr_retired(ret16)
`ifdef USEQ_STALL_CNT_EN
    , .stall_cnt(stall16)
`endif
  );

  microsequencer #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .ir_opcode(ir_opcode), .ben(ben), .mem_ready(mem_ready),
    .stateID(sid4), .illegal(ill4), .instr_retired(ret4)
`ifdef USEQ_STALL_CNT_EN
    , .stall_cnt(stall4)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic check_state(input string tag, input int s);
    chk({tag, "_state16"}, 32'(sid16), 32'(s));
    chk({tag, "_state4"}, 32'(sid4), 32'(s));
  endtask

  task automatic check_illegal(input string tag, input int v);
    chk({tag, "_illegal16"}, 32'(ill16), 32'(v));
    chk({tag, "_illegal4"}, 32'(ill4), 32'(v));
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_ret16"}, 32'(ret16), 32'(exp_ret % 65536));
    chk({tag, "_ret4"}, 32'(ret4), 32'(exp_ret % 16));
`ifdef USEQ_STALL_CNT_EN
    chk({tag, "_stall16"}, 32'(stall16), 32'(sat(exp_stall, 65535)));
    chk({tag, "_stall4"}, 32'(stall4), 32'(sat(exp_stall, 15)));
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_ret = 0;
    exp_stall = 0;
    check_state("reset", 18);
    check_illegal("reset", 0);
    check_counts("reset");
  endtask

  // Starts in FETCH; ends in FETCH (legal) or TRAPHALT (illegal). Ignored inputs carry noise.
  task automatic run_instr(input logic [3:0] op, input logic b, input int waits);
    logic legal;
    legal = (op == 4'd0) || (op == 4'd1) || (op == 4'd5) || (op == 4'd9) ||
            (op == 4'd12) || (op == 4'd13) || (op == 4'd14);
    mem_ready = (waits == 0);
    ben = ~b;
    ir_opcode = ~op;
    step();
    check_state("memrd", 33);
    for (int i = 0; i < waits; i++) begin
      step();
      exp_stall++;
      check_state("memwait", 33);
      mem_ready = (i == waits - 1);
    end
    step();
    check_state("ldir", 35);
    mem_ready = 1'b0;
    ir_opcode = op;
    step();
    check_state("decode", 32);
    step();
    if (!legal) begin
      check_state("trap", 63);
      check_illegal("trap", 1);
      check_counts("trap");
      return;
    end
    check_state("exec", int'(op));
    ir_opcode = ~op;
    if (op == 4'd0) begin
      ben = b;
      step();
      if (b) begin
        check_state("brtaken", 22);
        ben = 1'b0;
        step();
      end
    end else begin
      step();
    end
    exp_ret++;
    check_state("retire", 18);
    check_illegal("retire", 0);
    check_counts("retire");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout reached without finishing");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] bad_ops [8];
    bad_ops = '{4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11, 4'd15};

    do_reset();

    run_instr(4'd1, 1'b0, 0);
    run_instr(4'd0, 1'b1, 0);
    run_instr(4'd0, 1'b0, 0);
    run_instr(4'd5, 1'b0, 3);
    run_instr(4'd9, 1'b1, 0);
    run_instr(4'd12, 1'b0, 0);
    run_instr(4'd13, 1'b1, 0);
    run_instr(4'd14, 1'b0, 0);

    // Eight more retirements take the 4-bit counter through 15 -> 0; long wait saturates stall4.
    for (int i = 0; i < 8; i++) begin
      run_instr(4'd1, 1'b0, (i == 2) ? 20 : 0);
    end

    // Reset while parked in a memory wait.
    mem_ready = 1'b0;
    step();
    check_state("pre_rst_memrd", 33);
    step();
    exp_stall++;
    check_state("pre_rst_wait", 33);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_ret = 0;
    exp_stall = 0;
    check_state("rst_in_wait", 18);
    check_counts("rst_in_wait");
    run_instr(4'd1, 1'b0, 0);

    // Opcode 4 traps and holds regardless of other inputs.
    run_instr(4'd4, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      ben = 1'($urandom_range(0, 1));
      ir_opcode = 4'($urandom_range(0, 15));
      step();
      check_state("hold", 63);
      check_illegal("hold", 1);
    end
    check_counts("hold");
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_ret = 0;
    exp_stall = 0;
    check_state("rst_from_trap", 18);
    check_illegal("rst_from_trap", 0);

    foreach (bad_ops[k]) begin
      run_instr(bad_ops[k], 1'b0, 0);
      do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
